arm_multicycle_ctrl: RTL and testbench
======================================

# arm_multicycle_ctrl

Multicycle control unit for the ARM datapath: a Moore state machine sequences fetch, decode, execute, memory and writeback over several cycles, with a shared ALU/memory. It adds conditional execution with an internal NZCV flags register, and a parametrised ALU-control width with EOR/BIC support. It sits between the instruction register and the multicycle datapath, and replaces single-cycle decoding for the multicycle core.

## Interface
- `ALUCTRL_W`, default 3: ALUControl width, must be ≥3; upper bits are driven 0.
- `EXT_OPS`, default 1: when 1, EOR and BIC are decoded; when 0, they are illegal.
- `clk` in 1: single clock; every register updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `Cond` in 4: Instr[31:28].
- `Op` in 2: Instr[27:26].
- `Funct` in 6: Instr[25:20].
- `Rd` in 4: Instr[15:12].
- `ALUFlags` in 4: NZCV from the ALU this cycle.
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite` out 1 each: write enables.
- `AdrSrc` out 1: memory address select, 0=PC, 1=ALUOut.
- `ResultSrc` out 2: 00=ALUOut, 01=Data, 10=ALUResult.
- `ALUSrcA` out 1: 0=RD1, 1=PC.
- `ALUSrcB` out 2: 00=RD2, 01=ExtImm, 10=constant 4.
- `ImmSrc`, `RegSrc` out 2 each: same encodings as the single-cycle decoder.
- `ALUControl` out ALUCTRL_W: ALU operation.
- `Flags` out 4: registered NZCV.
- `Illegal` out 1: one-cycle pulse on an unimplemented instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- Outputs are decoded from state only; `Flags` and `CondExR` are registers.
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Always goes to DECODE.
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10. Latches CondExR = cond_check(Cond, Flags). Next state:
  - Op=01 → MEMADR.
  - Op=00 with Funct[5]=1 → EXECI.
  - Op=00 with Funct[5]=0 → EXECR.
  - Op=10 → BRANCH.
  - Op=11, or an undecodable DP cmd → FETCH with Illegal=1.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 → MEMRD; Funct[0]=0 → MEMWR.
- **MEMRD:** AdrSrc=1, then MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=CondExR, PCWrite=CondExR & (Rd==15).
- **MEMWR:** AdrSrc=1, MemWrite=CondExR.
- **EXECR / EXECI:** ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl decoded from Funct[4:1]:
  - ADD 0100→0, SUB 0010→1, AND 0000→2, ORR 1100→3, MOV 1101→4.
  - CMP 1010→1.
  - EOR 0001→5 and BIC 1110→6, only when EXT_OPS=1.
- **Flag update:** at the end of EXEC, if CondExR and Funct[0], N and Z are loaded. C and V are loaded only for ADD/SUB/CMP. Next state is ALUWB, except CMP, which goes to FETCH.
- **ALUWB:** ResultSrc=00, RegWrite=CondExR, PCWrite=CondExR & (Rd==15).
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExR.
- All unlisted enables are 0 in every state. ALUControl defaults to 0 (ADD) outside EXEC.
- **ImmSrc/RegSrc** per Op: DP-imm 00/00, DP-reg 00/00, LDR 01/00, STR 01/10, B 10/01.
- **cond_check:** EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL(1110)=1; 1111=0.

## Timing
- **Reset:** state=FETCH, Flags=0000, CondExR=0.
- **While reset is high:** PCWrite, MemWrite, RegWrite and IRWrite are forced to 0, and Illegal=0. Other outputs take their FETCH values.
- **Reset mid-instruction:** the state returns to FETCH immediately. No partial write completes after reset rises.
- **Cycles per instruction (FETCH to the next FETCH):**
  - LDR 5.
  - STR 4.
  - DP 4.
  - CMP 3.
  - B 3.
  - Illegal 2.
- **Condition timing:** CondExR is fixed from DECODE onward. A flag update in EXEC does not affect the same instruction's writeback gate.
- Flags are visible to the next instruction's DECODE.

## Structure
- Package `arm_ctrl_pkg` holds:
  - `state_t` enum.
  - ALU op localparams (ADD..BIC).
  - Condition-code localparams.
  - Op encodings.
- Sub-module `arm_cond_check`: combinational; inputs Cond and Flags; output CondEx.

## Test plan
- **Reset:** assert reset mid-MEMRD → state=FETCH next observation; Flags=0000; all write enables 0 while reset is high.
- **ADDS R1,R2,#5:** Cond=1110, Op=00, Funct=101001, Rd=1, ALUFlags=0100 → sequence F,D,EXECI,ALUWB. ALUControl=0 in EXECI. RegWrite=1 in ALUWB. Flags=0100 after EXECI.
- **LDR PC:** Op=01, Funct=011001, Rd=15 → 5 cycles. MEMWB has RegWrite=1, PCWrite=1, ResultSrc=01.
- **BEQ with Flags Z=0:** Cond=0000, Op=10 → BRANCH with PCWrite=0; back in FETCH after 3 cycles.
- **CMP then BNE:** CMP sets Z=1 (ALUFlags=0100) → 3-cycle CMP with no RegWrite. The following Cond=0001 branch takes PCWrite=0 in BRANCH.
- **Illegal:** Op=11 → Illegal=1 for exactly the DECODE cycle, then FETCH. With EXT_OPS=0, EOR (Funct[4:1]=0001) → same behaviour.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM multicycle control unit:
// FSM states, ALU operations, condition codes and instruction field codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_MOV = 3'd4;
    localparam logic [2:0] ALU_EOR = 3'd5;
    localparam logic [2:0] ALU_BIC = 3'd6;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // Data-processing cmd field, Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

    function automatic logic dp_cmd_legal(input logic [3:0] cmd, input logic ext_ops);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_MOV, CMD_CMP: return 1'b1;
            CMD_EOR, CMD_BIC:                                     return ext_ops;
            default:                                              return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] dp_alu_op(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: return ALU_ADD;
            CMD_SUB: return ALU_SUB;
            CMD_CMP: return ALU_SUB;
            CMD_AND: return ALU_AND;
            CMD_ORR: return ALU_ORR;
            CMD_MOV: return ALU_MOV;
            CMD_EOR: return ALU_EOR;
            CMD_BIC: return ALU_BIC;
            default: return ALU_ADD;
        endcase
    endfunction

    // Only arithmetic ops produce meaningful carry/overflow
    function automatic logic cmd_sets_cv(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-code evaluator: decides whether an instruction
// with condition field Cond executes given the current NZCV flags.
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign {n, z, c, v} = Flags;

    always_comb begin
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/memory/
// writeback, with conditional execution gated by an internal NZCV register.
module arm_multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EXT_OPS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           Flags,
    output logic                 Illegal
);

    state_t     state;
    logic [3:0] flags_r;
    logic       cond_ex_r;
    logic       cond_ex;
    logic [3:0] cmd;
    logic       decode_illegal;
    logic       rd_is_pc;
    logic [2:0] alu_op;

    assign cmd            = Funct[4:1];
    assign rd_is_pc       = (Rd == PC_REG);
    assign decode_illegal = (Op == OP_UNDEF) || ((Op == OP_DP) && !dp_cmd_legal(cmd, EXT_OPS));
    assign Flags          = flags_r;

    arm_cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_r),
        .CondEx (cond_ex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            flags_r   <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    cond_ex_r <= cond_ex;
                    if (decode_illegal)    state <= FETCH;
                    else if (Op == OP_MEM) state <= MEMADR;
                    else if (Op == OP_BR)  state <= BRANCH;
                    else if (Funct[5])     state <= EXECI;
                    else                   state <= EXECR;
                end
                MEMADR: state <= Funct[0] ? MEMRD : MEMWR;
                MEMRD:  state <= MEMWB;
                EXECR, EXECI: begin
                    // S-bit flag update; the writeback gate stays on the DECODE-time cond_ex_r
                    if (cond_ex_r && Funct[0]) begin
                        flags_r[3:2] <= ALUFlags[3:2];
                        if (cmd_sets_cv(cmd)) flags_r[1:0] <= ALUFlags[1:0];
                    end
                    state <= (cmd == CMD_CMP) ? FETCH : ALUWB;
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        alu_op    = ALU_ADD;
        Illegal   = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                Illegal   = decode_illegal;
            end
            MEMADR: ALUSrcB = SRCB_IMM;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = cond_ex_r;
                PCWrite   = cond_ex_r && rd_is_pc;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_r;
            end
            EXECR:  alu_op = dp_alu_op(cmd);
            EXECI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = dp_alu_op(cmd);
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = cond_ex_r;
                PCWrite   = cond_ex_r && rd_is_pc;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = cond_ex_r;
            end
            default: ;
        endcase
        // State is already FETCH during reset; only the side effects must be killed
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
            Illegal  = 1'b0;
        end
    end

    always_comb begin
        ALUControl      = '0;
        ALUControl[2:0] = alu_op;
    end

    always_comb begin
        case (Op)
            OP_MEM: begin
                ImmSrc = 2'b01;
                RegSrc = Funct[0] ? 2'b00 : 2'b10;
            end
            OP_BR: begin
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: begin
                ImmSrc = 2'b00;
                RegSrc = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench for arm_multicycle_ctrl: an instruction-level model predicts
// every cycle's outputs and flags; directed cases pin the model with literals.
module tb_arm_multicycle_ctrl;

    typedef enum int {K_LDR, K_STR, K_DP, K_CMP, K_B, K_ILL} kind_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Cond = 4'hE;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'd0;
    logic [3:0] ALUFlags = 4'b0;

    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Illegal;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] Flags;

    logic       nx_PCWrite, nx_MemWrite, nx_RegWrite, nx_IRWrite, nx_AdrSrc, nx_ALUSrcA, nx_Illegal;
    logic [1:0] nx_ResultSrc, nx_ALUSrcB, nx_ImmSrc, nx_RegSrc;
    logic [3:0] nx_ALUControl;
    logic [3:0] nx_Flags;

    arm_multicycle_ctrl #(.ALUCTRL_W(3), .EXT_OPS(1'b1)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .Illegal(Illegal)
    );

    arm_multicycle_ctrl #(.ALUCTRL_W(4), .EXT_OPS(1'b0)) dut_noext (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(nx_PCWrite), .MemWrite(nx_MemWrite),
        .RegWrite(nx_RegWrite), .IRWrite(nx_IRWrite), .AdrSrc(nx_AdrSrc),
        .ResultSrc(nx_ResultSrc), .ALUSrcA(nx_ALUSrcA), .ALUSrcB(nx_ALUSrcB),
        .ImmSrc(nx_ImmSrc), .RegSrc(nx_RegSrc), .ALUControl(nx_ALUControl),
        .Flags(nx_Flags), .Illegal(nx_Illegal)
    );

    always #5 clk = ~clk;

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,ALUControl,Illegal}
    logic [17:0] dut_vec;
    assign dut_vec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
                      ALUSrcB, ImmSrc, RegSrc, ALUControl, Illegal};

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_vec = '0;
    logic [3:0]  exp_flags = '0;
    string       exp_tag = "idle";
    bit          chk_en = 1'b0;
    logic [3:0]  mflags = '0;
    logic [17:0] snap [5];
    int          icount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check({exp_tag, ".outs"}, 32'(dut_vec), 32'(exp_vec));
            check({exp_tag, ".flags"}, 32'(Flags), 32'(exp_flags));
        end
    end

    function automatic logic [17:0] pack(input bit pcw, memw, regw, irw, adr,
                                         input logic [1:0] res, input bit asa,
                                         input logic [1:0] asb, imm, rs,
                                         input logic [2:0] alu, input bit ill);
        return {pcw, memw, regw, irw, adr, res, asa, asb, imm, rs, alu, ill};
    endfunction

    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        return cond[0] ? !base : base;
    endfunction

    function automatic void classify(input logic [1:0] op, input logic [5:0] funct, input bit ext,
                                     output kind_t k, output logic [2:0] aluop, output bit cv);
        logic [3:0] cmd;
        cmd = funct[4:1];
        aluop = 3'd0;
        cv = 1'b0;
        k = K_ILL;
        if (op == 2'b01) k = funct[0] ? K_LDR : K_STR;
        else if (op == 2'b10) k = K_B;
        else if (op == 2'b00) begin
            k = K_DP;
            case (cmd)
                4'b0100: begin aluop = 3'd0; cv = 1'b1; end
                4'b0010: begin aluop = 3'd1; cv = 1'b1; end
                4'b0000: aluop = 3'd2;
                4'b1100: aluop = 3'd3;
                4'b1101: aluop = 3'd4;
                4'b1010: begin k = K_CMP; aluop = 3'd1; cv = 1'b1; end
                4'b0001: if (ext) aluop = 3'd5; else k = K_ILL;
                4'b1110: if (ext) aluop = 3'd6; else k = K_ILL;
                default: k = K_ILL;
            endcase
        end
    endfunction

    function automatic int cycles_of(input kind_t k);
        case (k)
            K_LDR:   return 5;
            K_STR:   return 4;
            K_DP:    return 4;
            K_CMP:   return 3;
            K_B:     return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] imm_rs(input logic [1:0] op, input logic [5:0] funct);
        case (op)
            2'b01:   return {2'b01, funct[0] ? 2'b00 : 2'b10};
            2'b10:   return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [17:0] expect_cycle(input kind_t k, input int c, input bit ce,
                                                 input logic [1:0] op, input logic [5:0] funct,
                                                 input logic [3:0] rd, input logic [2:0] aluop);
        logic [1:0] imm, rs;
        logic [1:0] exec_b;
        bit         wpc;
        {imm, rs} = imm_rs(op, funct);
        exec_b = funct[5] ? 2'b01 : 2'b00;
        wpc = ce && (rd == 4'd15);
        if (c == 0) return pack(1, 0, 0, 1, 0, 2'b10, 1, 2'b10, imm, rs, 3'd0, 0);
        if (c == 1) return pack(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, imm, rs, 3'd0, k == K_ILL);
        if (c == 2) begin
            case (k)
                K_LDR, K_STR: return pack(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, imm, rs, 3'd0, 0);
                K_DP, K_CMP:  return pack(0, 0, 0, 0, 0, 2'b00, 0, exec_b, imm, rs, aluop, 0);
                default:      return pack(ce, 0, 0, 0, 0, 2'b10, 0, 2'b01, imm, rs, 3'd0, 0);
            endcase
        end
        if (c == 3) begin
            case (k)
                K_LDR:   return pack(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, imm, rs, 3'd0, 0);
                K_STR:   return pack(0, ce, 0, 0, 1, 2'b00, 0, 2'b00, imm, rs, 3'd0, 0);
                default: return pack(wpc, 0, ce, 0, 0, 2'b00, 0, 2'b00, imm, rs, 3'd0, 0);
            endcase
        end
        return pack(wpc, 0, ce, 0, 0, 2'b01, 0, 2'b00, imm, rs, 3'd0, 0);
    endfunction

    // Entered at posedge+1 of the FETCH cycle; leaves at posedge+1 of the next
    // instruction's FETCH, or at negedge+1 of cycle stop_at when stopping early.
    task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic [3:0] af, input bit af_rand,
                             input int stop_at);
        kind_t      k;
        logic [2:0] aluop;
        bit         cv, ce;
        int         n;
        classify(op, funct, 1'b1, k, aluop, cv);
        ce = cond_ok(cond, mflags);
        n = cycles_of(k);
        icount++;
        Cond = cond; Op = op; Funct = funct; Rd = rd;
        for (int c = 0; c < n; c++) begin
            ALUFlags = af_rand ? 4'($urandom) : af;
            exp_vec = expect_cycle(k, c, ce, op, funct, rd, aluop);
            exp_flags = mflags;
            exp_tag = $sformatf("i%0d.k%0d.c%0d", icount, int'(k), c);
            chk_en = 1'b1;
            @(negedge clk); #1;
            snap[c] = dut_vec;
            if (c == 2 && (k == K_DP || k == K_CMP) && ce && funct[0])
                mflags = {ALUFlags[3:2], cv ? ALUFlags[1:0] : mflags[1:0]};
            if (c == stop_at) return;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        logic [1:0] imm, rs;
        reset = 1'b1;
        mflags = 4'b0000;
        {imm, rs} = imm_rs(Op, Funct);
        exp_vec = pack(0, 0, 0, 0, 0, 2'b10, 1, 2'b10, imm, rs, 3'd0, 0);
        exp_flags = 4'b0000;
        exp_tag = "reset";
        chk_en = 1'b1;
        #1;
        check("reset.enables_now", 32'({PCWrite, MemWrite, RegWrite, IRWrite, Illegal}), 32'd0);
        check("reset.flags_now", 32'(Flags), 32'd0);
        @(negedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] cmd_pool [10];
        cmd_pool = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1010,
                     4'b1100, 4'b1101, 4'b1110, 4'b0011, 4'b1000};

        do_reset();

        // BEQ with Z=0 after reset: not taken
        run_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000, 1'b0, -1);
        check("beq.branch_pcwrite", 32'(snap[2][17]), 32'd0);

        // ADDS R1,R2,#5 with ALU reporting Z
        run_instr(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0100, 1'b0, -1);
        check("adds.execi_alucontrol", 32'(snap[2][3:1]), 32'd0);
        check("adds.execi_srcb", 32'(snap[2][9:8]), 32'd1);
        check("adds.aluwb_regwrite", 32'(snap[3][15]), 32'd1);
        check("adds.flags", 32'(Flags), 32'h4);

        // LDR PC
        run_instr(4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000, 1'b1, -1);
        check("ldrpc.memwb_regwrite", 32'(snap[4][15]), 32'd1);
        check("ldrpc.memwb_pcwrite", 32'(snap[4][17]), 32'd1);
        check("ldrpc.memwb_resultsrc", 32'(snap[4][12:11]), 32'd1);

        // CMP sets Z, then BNE is not taken
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 1'b0, -1);
        check("cmp.alucontrol", 32'(snap[2][3:1]), 32'd1);
        check("cmp.no_regwrite", 32'({snap[0][15], snap[1][15], snap[2][15]}), 32'd0);
        check("cmp.flags", 32'(Flags), 32'h4);
        run_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000, 1'b1, -1);
        check("bne.branch_pcwrite", 32'(snap[2][17]), 32'd0);

        // Op=11 illegal
        run_instr(4'hE, 2'b11, 6'b000000, 4'd3, 4'b0000, 1'b1, -1);
        check("undef.decode_illegal", 32'(snap[1][0]), 32'd1);
        check("undef.fetch_no_illegal", 32'(snap[0][0]), 32'd0);

        // Reset arriving mid-MEMRD of an LDR
        run_instr(4'hE, 2'b01, 6'b011001, 4'd4, 4'b0000, 1'b1, 3);
        do_reset();
        check("reset.flags_cleared", 32'(Flags), 32'd0);

        for (int i = 0; i < 250; i++) begin
            logic [3:0] cond, rd;
            logic [1:0] op;
            logic [5:0] funct;
            int         sel;
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            funct = 6'($urandom);
            if (op == 2'b00) funct[4:1] = cmd_pool[$urandom_range(0, 9)];
            cond = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                run_instr(cond, op, funct, rd, 4'b0000, 1'b1, $urandom_range(0, 1));
                do_reset();
            end else begin
                run_instr(cond, op, funct, rd, 4'b0000, 1'b1, -1);
            end
        end

        // EXT_OPS=0 instance: EOR is illegal, SUB drives a 4-bit ALUControl
        do_reset();
        chk_en = 1'b0;
        Cond = 4'hE; Op = 2'b00; Funct = 6'b000011; Rd = 4'd2;
        @(negedge clk); #1;
        check("noext.eor.fetch_irwrite", 32'(nx_IRWrite), 32'd1);
        check("noext.eor.fetch_illegal", 32'(nx_Illegal), 32'd0);
        @(posedge clk); #1; @(negedge clk); #1;
        check("noext.eor.decode_illegal", 32'(nx_Illegal), 32'd1);
        check("ext.eor.decode_illegal", 32'(Illegal), 32'd0);
        @(posedge clk); #1; @(negedge clk); #1;
        check("noext.eor.back_in_fetch", 32'(nx_IRWrite), 32'd1);
        check("noext.eor.illegal_cleared", 32'(nx_Illegal), 32'd0);
        check("ext.eor.execr_alucontrol", 32'(ALUControl), 32'd5);

        do_reset();
        chk_en = 1'b0;
        Cond = 4'hE; Op = 2'b00; Funct = 6'b000100; Rd = 4'd5;
        @(negedge clk); #1;
        @(posedge clk); #1; @(negedge clk); #1;
        check("noext.sub.decode_illegal", 32'(nx_Illegal), 32'd0);
        @(posedge clk); #1; @(negedge clk); #1;
        check("noext.sub.execr_alucontrol", 32'(nx_ALUControl), 32'h1);
        check("noext.sub.execr_srcb", 32'(nx_ALUSrcB), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
